// File: rtl/lsu.sv
// lsu: load/store unit bridging the execute stage to a single-outstanding
// request/ack bus, with alignment checking, lane steering and a wait timeout.
module lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rd_addr_i,
   input  logic [31:0] rd_data_i,
   input  logic        rd_wen_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic [2:0]  mem_size_i,
   input  logic        mem_we_i,
   input  logic        mem_re_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_data_o,
   output logic        rd_wen_o,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        timeout_o
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, next;
   logic [7:0]  cnt;
   logic [2:0]  size;
   logic [1:0]  lane;
   logic [4:0]  rd;
   logic        load;
   logic        access, misalign, start, done, tmo;
   logic [3:0]  be;
   logic [31:0] wdata, shifted, ldata;

   // Illegal size codes (011, 11x) are folded into the misalign condition.
   assign access   = mem_we_i | mem_re_i;
   assign misalign = (mem_size_i[1:0] == 2'b11) | (mem_size_i[2] & mem_size_i[1]) |
                     (mem_size_i[1:0] == 2'b01 & mem_addr_i[0]) |
                     (mem_size_i[1:0] == 2'b10 & mem_addr_i[1:0] != 2'b00);
   assign start    = state == IDLE & access & ~misalign;
   assign done     = state == BUSY & bus_ack_i;
   assign tmo      = state == BUSY & ~bus_ack_i & cnt == 8'(TIMEOUT - 1);

   assign be    = mem_size_i[1:0] == 2'b00 ? 4'b0001 << mem_addr_i[1:0] :
                  mem_size_i[1:0] == 2'b01 ? 4'b0011 << mem_addr_i[1:0] : 4'b1111;
   assign wdata = mem_size_i[1:0] == 2'b00 ? {4{mem_data_i[7:0]}} :
                  mem_size_i[1:0] == 2'b01 ? {2{mem_data_i[15:0]}} : mem_data_i;

   assign shifted = bus_rdata_i >> {lane, 3'b000};
   assign ldata   = size[1:0] == 2'b00 ? {{24{~size[2] & shifted[7]}}, shifted[7:0]} :
                    size[1:0] == 2'b01 ? {{16{~size[2] & shifted[15]}}, shifted[15:0]} : shifted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      if (state == IDLE && start)        next = BUSY;
      else if (state == BUSY && (done || tmo)) next = IDLE;
   end

   // Gated by rst_n so the pipeline is never held while in reset.
   always_comb stall_o = rst_n & (state == IDLE ? start : ~bus_ack_i & ~tmo);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
         size        <= '0;
         lane        <= '0;
         rd          <= '0;
         load        <= 1'b0;
         rd_addr_o   <= '0;
         rd_data_o   <= '0;
         rd_wen_o    <= 1'b0;
         misalign_o  <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         cnt        <= start ? 8'd0 : (state == BUSY & ~bus_ack_i) ? cnt + 8'd1 : cnt;
         misalign_o <= state == IDLE & access & misalign;
         timeout_o  <= tmo;
         if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_wdata_o <= wdata;
            bus_be_o    <= be;
            size        <= mem_size_i;
            lane        <= mem_addr_i[1:0];
            rd          <= rd_addr_i;
            load        <= mem_re_i;
         end else if (done || tmo) begin
            bus_req_o <= 1'b0;
         end
         rd_wen_o  <= state == IDLE ? ~access & rd_wen_i : done & load;
         rd_addr_o <= state == IDLE ? rd_addr_i : done ? rd : rd_addr_o;
         rd_data_o <= state == IDLE ? rd_data_i : done ? ldata : rd_data_o;
      end
   end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with TIMEOUT=4.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic [31:0] rd_data_i = '0;
   logic        rd_wen_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_data_i = '0;
   logic [2:0]  mem_size_i = '0;
   logic        mem_we_i = 1'b0;
   logic        mem_re_i = 1'b0;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i = 1'b0;
   logic [31:0] bus_rdata_i = '0;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;
   logic        rd_wen_o, stall_o, misalign_o, timeout_o;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_wen_i(rd_wen_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_size_i(mem_size_i),
      .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
      .stall_o(stall_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      rd_addr_i = '0; rd_data_i = '0; rd_wen_i = 1'b0;
      mem_addr_i = '0; mem_data_i = '0; mem_size_i = '0;
      mem_we_i = 1'b0; mem_re_i = 1'b0;
   endtask

   task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] sz, input logic [4:0] rda);
      mem_we_i = we; mem_re_i = ~we; mem_addr_i = addr; mem_data_i = data;
      mem_size_i = sz; rd_addr_i = rda;
   endtask

   task automatic test_reset;
      mem_op(1'b0, 32'h0, 32'h0, 3'b010, 5'd1);
      bus_ack_i = 1'b1;
      #2;
      checks++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== 70'd0) begin
         errors++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h be=%b exp all 0",
                            bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o);
      end
      checks++;
      if ({rd_addr_o, rd_data_o, rd_wen_o, misalign_o, timeout_o} !== 40'd0) begin
         errors++; $display("FAIL reset_rd: got rd=%0d data=%h wen=%b mis=%b tmo=%b exp all 0",
                            rd_addr_o, rd_data_o, rd_wen_o, misalign_o, timeout_o);
      end
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b exp 0", stall_o);
      end
      idle_inputs();
      bus_ack_i = 1'b0;
      #10 rst_n = 1'b1;
   endtask

   task automatic test_bypass;
      rd_addr_i = 5'd5; rd_data_i = 32'h1234; rd_wen_i = 1'b1;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL bypass_stall: got %b exp 0", stall_o);
      end
      cyc();
      checks++;
      if ({rd_addr_o, rd_data_o, rd_wen_o, stall_o} !== {5'd5, 32'h1234, 1'b1, 1'b0}) begin
         errors++; $display("FAIL bypass_out: got rd=%0d data=%h wen=%b stall=%b exp 5/00001234/1/0",
                            rd_addr_o, rd_data_o, rd_wen_o, stall_o);
      end
      rd_addr_i = 5'd0; rd_data_i = 32'hDEAD;
      cyc();
      checks++;
      if ({rd_addr_o, rd_data_o, rd_wen_o} !== {5'd0, 32'hDEAD, 1'b1}) begin
         errors++; $display("FAIL bypass_x0: got rd=%0d data=%h wen=%b exp 0/0000dead/1",
                            rd_addr_o, rd_data_o, rd_wen_o);
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_load_signed;
      int sc;
      mem_op(1'b0, 32'h103, 32'h0, 3'b000, 5'd7);
      #1;
      checks++;
      if ({stall_o, bus_req_o} !== 2'b10) begin
         errors++; $display("FAIL lb_accept: got stall=%b req=%b exp 1/0", stall_o, bus_req_o);
      end
      cyc();
      idle_inputs();
      checks++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, rd_wen_o} !== {1'b1, 1'b0, 32'h100, 4'b1000, 1'b0}) begin
         errors++; $display("FAIL lb_bus: got req=%b we=%b addr=%h be=%b wen=%b exp 1/0/00000100/1000/0",
                            bus_req_o, bus_we_o, bus_addr_o, bus_be_o, rd_wen_o);
      end
      sc = 0;
      repeat (3) begin
         #1;
         if (stall_o === 1'b1 && bus_req_o === 1'b1) sc++;
         cyc();
      end
      checks++;
      if (sc != 3 || bus_be_o !== 4'b1000) begin
         errors++; $display("FAIL lb_wait: got stall_cycles=%0d be=%b exp 3/1000", sc, bus_be_o);
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'h80AABBCC;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL lb_ack_stall: got %b exp 0", stall_o);
      end
      cyc();
      bus_ack_i = 1'b0;
      checks++;
      if ({rd_data_o, rd_addr_o, rd_wen_o, bus_req_o, timeout_o} !== {32'hFFFFFF80, 5'd7, 1'b1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL lb_result: got data=%h rd=%0d wen=%b req=%b tmo=%b exp ffffff80/7/1/0/0",
                            rd_data_o, rd_addr_o, rd_wen_o, bus_req_o, timeout_o);
      end
      cyc();
      checks++;
      if ({rd_wen_o, stall_o} !== 2'b00) begin
         errors++; $display("FAIL lb_after: got wen=%b stall=%b exp 0/0", rd_wen_o, stall_o);
      end
   endtask

   task automatic test_store_half;
      mem_op(1'b1, 32'h202, 32'h0000BEEF, 3'b001, 5'd9);
      rd_wen_i = 1'b1;
      cyc();
      idle_inputs();
      checks++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rd_wen_o} !==
          {1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF, 1'b0}) begin
         errors++; $display("FAIL sh_bus: got req=%b we=%b addr=%h be=%b wdata=%h wen=%b exp 1/1/00000200/1100/beefbeef/0",
                            bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rd_wen_o);
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
      cyc();
      bus_ack_i = 1'b0;
      checks++;
      if ({rd_wen_o, bus_req_o} !== 2'b00) begin
         errors++; $display("FAIL sh_ack: got wen=%b req=%b exp 0/0", rd_wen_o, bus_req_o);
      end
   endtask

   task automatic test_misalign;
      mem_op(1'b0, 32'h3, 32'h0, 3'b010, 5'd2);
      rd_wen_i = 1'b1;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL lw_mis_stall: got %b exp 0", stall_o);
      end
      cyc();
      idle_inputs();
      checks++;
      if ({misalign_o, bus_req_o, rd_wen_o} !== 3'b100) begin
         errors++; $display("FAIL lw_mis: got mis=%b req=%b wen=%b exp 1/0/0", misalign_o, bus_req_o, rd_wen_o);
      end
      mem_op(1'b0, 32'h0, 32'h0, 3'b011, 5'd2);
      cyc();
      idle_inputs();
      checks++;
      if ({misalign_o, bus_req_o} !== 2'b10) begin
         errors++; $display("FAIL illegal_size: got mis=%b req=%b exp 1/0", misalign_o, bus_req_o);
      end
      cyc();
      checks++;
      if ({misalign_o, bus_req_o} !== 2'b00) begin
         errors++; $display("FAIL mis_pulse: got mis=%b req=%b exp 0/0", misalign_o, bus_req_o);
      end
   endtask

   task automatic test_timeout;
      int sc;
      mem_op(1'b0, 32'h40, 32'h0, 3'b010, 5'd6);
      cyc();
      idle_inputs();
      sc = 0;
      repeat (3) begin
         #1;
         if (stall_o === 1'b1 && bus_req_o === 1'b1) sc++;
         cyc();
      end
      #1;
      checks++;
      if (sc != 3 || stall_o !== 1'b0 || bus_req_o !== 1'b1) begin
         errors++; $display("FAIL to_wait: got stall_cycles=%0d abort_stall=%b req=%b exp 3/0/1", sc, stall_o, bus_req_o);
      end
      cyc();
      checks++;
      if ({timeout_o, bus_req_o, rd_wen_o} !== 3'b100) begin
         errors++; $display("FAIL to_abort: got tmo=%b req=%b wen=%b exp 1/0/0", timeout_o, bus_req_o, rd_wen_o);
      end
      cyc();
      checks++;
      if (timeout_o !== 1'b0) begin
         errors++; $display("FAIL to_pulse: got %b exp 0", timeout_o);
      end
      mem_op(1'b0, 32'h44, 32'h0, 3'b010, 5'd3);
      cyc();
      idle_inputs();
      repeat (3) cyc();
      bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
      cyc();
      bus_ack_i = 1'b0;
      checks++;
      if ({timeout_o, rd_data_o, rd_addr_o, rd_wen_o, bus_req_o} !== {1'b0, 32'h12345678, 5'd3, 1'b1, 1'b0}) begin
         errors++; $display("FAIL to_ack_prio: got tmo=%b data=%h rd=%0d wen=%b req=%b exp 0/12345678/3/1/0",
                            timeout_o, rd_data_o, rd_addr_o, rd_wen_o, bus_req_o);
      end
   endtask

   task automatic test_reset_busy;
      mem_op(1'b0, 32'h80, 32'h0, 3'b010, 5'd8);
      cyc();
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_req_o, stall_o} !== 2'b00) begin
         errors++; $display("FAIL rst_busy: got req=%b stall=%b exp 0/0", bus_req_o, stall_o);
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAAAAAA;
      #2 rst_n = 1'b1;
      cyc();
      bus_ack_i = 1'b0;
      checks++;
      if ({rd_wen_o, bus_req_o} !== 2'b00) begin
         errors++; $display("FAIL rst_stale_ack: got wen=%b req=%b exp 0/0", rd_wen_o, bus_req_o);
      end
      mem_op(1'b0, 32'h2, 32'h0, 3'b101, 5'd4);
      cyc();
      idle_inputs();
      checks++;
      if ({bus_req_o, bus_addr_o, bus_be_o} !== {1'b1, 32'h0, 4'b1100}) begin
         errors++; $display("FAIL lhu_bus: got req=%b addr=%h be=%b exp 1/00000000/1100", bus_req_o, bus_addr_o, bus_be_o);
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'hF00D0000;
      cyc();
      bus_ack_i = 1'b0;
      checks++;
      if ({rd_data_o, rd_addr_o, rd_wen_o} !== {32'h0000F00D, 5'd4, 1'b1}) begin
         errors++; $display("FAIL lhu_result: got data=%h rd=%0d wen=%b exp 0000f00d/4/1", rd_data_o, rd_addr_o, rd_wen_o);
      end
   endtask

   initial begin
      test_reset();
      cyc();
      test_bypass();
      test_load_signed();
      test_store_half();
      test_misalign();
      test_timeout();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
